// File: rtl/lpc_postcode_pkg.sv
// Shared constants and helpers for the LPC POST-code capture FIFO.
package lpc_postcode_pkg;

  localparam logic [15:0] DEF_POST_ADDR = 16'h0080;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0A82;

  // STAT register layout: {overflow, empty, count[5:0]}
  localparam int unsigned STAT_OVF     = 7;
  localparam int unsigned STAT_EMPTY   = 6;
  localparam int unsigned STAT_CNT_MSB = 5;
  localparam int unsigned STAT_CNT_LSB = 0;
  localparam int unsigned CNT_W        = 6;

  localparam logic [7:0] EMPTY_READ = 8'hFF;

  // Bit width of one POST code
  function automatic int unsigned code_width(input int unsigned code_bytes);
    return 8 * code_bytes;
  endfunction

endpackage

// File: rtl/postcode_ring.sv
// DEPTH-entry ring buffer of POST codes; a push while full overwrites the oldest entry.
module postcode_ring
  import lpc_postcode_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A pop against an empty buffer is dropped, even when a push lands in the same cycle
  assign pop_ok  = pop_i && !empty;

  // Pointer/count update: push applied first, then pop; pointers wrap naturally (power-of-two DEPTH)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (full) rd_ptr_d = rd_ptr_q + AW'(1);
        else      cnt_d    = cnt_q + CNT_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_d + AW'(1);
        cnt_d    = cnt_d - CNT_W'(1);
      end
    end
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: rtl/lpc_postcode_fifo.sv
// LPC POST-code capture: staged multi-byte codes into a history ring with STAT/DATA read-back.
// Optional build macro POSTCODE_DEDUP_EN: drop a commit equal to the current postcode.
module lpc_postcode_fifo
  import lpc_postcode_pkg::*;
#(
  parameter int unsigned CODE_BYTES = 1,
  parameter int unsigned DEPTH      = 16,
  parameter logic [15:0] POST_ADDR  = DEF_POST_ADDR,
  parameter logic [15:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic                                lclk,
  input  logic                                lreset_n,
  input  logic                                lpc_en,
  input  logic [15:0]                         lpc_addr,
  input  logic [7:0]                          din,
  input  logic                                io_wren,
  input  logic                                io_rden,
  output logic [7:0]                          dout,
  output logic                                rd_hit,
  output logic [code_width(CODE_BYTES)-1:0]   postcode,
  output logic [5:0]                          count
);

  localparam int unsigned    CW        = code_width(CODE_BYTES);
  localparam int unsigned    BIW       = (CODE_BYTES > 1) ? $clog2(CODE_BYTES) : 1;
  localparam logic [15:0]    DATA_ADDR = STAT_ADDR + 16'd1;
  localparam logic [15:0]    LAST_OFFS = 16'(CODE_BYTES - 1);
  localparam logic [BIW-1:0] LAST_IDX  = BIW'(CODE_BYTES - 1);
  localparam logic [CW-1:0]  LOW_MASK  = CW'((64'd1 << (8 * (CODE_BYTES - 1))) - 64'd1);

  logic             wr_take, rd_take;
  logic [15:0]      win_offs;
  logic             win_hit, stat_hit, data_hit;
  logic             push, pop, flush;
  logic [CW-1:0]    code;
  logic [CW-1:0]    stage_q, stage_d;
  logic [CW-1:0]    postcode_q, postcode_d;
  logic             ovf_q, ovf_d;
  logic [BIW-1:0]   bidx_q, bidx_d;
  logic [CW-1:0]    head;
  logic [CNT_W-1:0] cnt;
  logic             empty, full;
  logic [7:0]       data_byte;

  assign wr_take  = lpc_en && io_wren;
  assign rd_take  = lpc_en && io_rden;
  assign win_offs = lpc_addr - POST_ADDR;
  assign win_hit  = (win_offs < 16'(CODE_BYTES));
  assign stat_hit = (lpc_addr == STAT_ADDR);
  assign data_hit = (lpc_addr == DATA_ADDR);

  // Assembled code for a commit: din becomes the top byte over the staged lower bytes
  assign code = (stage_q & LOW_MASK) | (CW'(din) << (8 * (CODE_BYTES - 1)));

  // Capture, STAT control and DATA byte sequencing
  always_comb begin
    stage_d    = stage_q;
    postcode_d = postcode_q;
    ovf_d      = ovf_q;
    bidx_d     = bidx_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    if (wr_take && win_hit) begin
      if (win_offs == LAST_OFFS) begin
        postcode_d = code;
`ifdef POSTCODE_DEDUP_EN
        push       = (code != postcode_q);
`else
        push       = 1'b1;
`endif
      end else begin
        for (int unsigned k = 0; k + 1 < CODE_BYTES; k++) begin
          if (win_offs == 16'(k)) stage_d[8*k +: 8] = din;
        end
      end
    end

    if (push && full) ovf_d = 1'b1;

    if (wr_take && stat_hit) begin
      if (din[STAT_OVF]) ovf_d = 1'b0;
      if (din[STAT_EMPTY]) begin
        flush  = 1'b1;
        bidx_d = '0;
      end
    end

    if (rd_take && data_hit && !empty) begin
      if (bidx_q == LAST_IDX) begin
        pop    = 1'b1;
        bidx_d = '0;
      end else begin
        bidx_d = bidx_q + BIW'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      stage_q    <= '0;
      postcode_q <= '0;
      ovf_q      <= 1'b0;
      bidx_q     <= '0;
    end else begin
      stage_q    <= stage_d;
      postcode_q <= postcode_d;
      ovf_q      <= ovf_d;
      bidx_q     <= bidx_d;
    end
  end

  postcode_ring #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk         (lclk),
    .rst_n       (lreset_n),
    .push_i      (push),
    .push_data_i (code),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .count_o     (cnt),
    .empty_o     (empty),
    .full_o      (full)
  );

  // Read-back mux, combinational from address and held state
  always_comb begin
    data_byte = EMPTY_READ;
    for (int unsigned k = 0; k < CODE_BYTES; k++) begin
      if (!empty && bidx_q == BIW'(k)) data_byte = head[8*k +: 8];
    end
    dout = 8'h00;
    if (stat_hit) begin
      dout[STAT_OVF]                   = ovf_q;
      dout[STAT_EMPTY]                 = empty;
      dout[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt;
    end else if (data_hit) begin
      dout = data_byte;
    end
  end

  assign rd_hit   = stat_hit || data_hit;
  assign postcode = postcode_q;
  assign count    = cnt;

endmodule

// File: tb/tb_lpc_postcode_fifo.sv
// Bench: a 1-byte and a 2-byte instance share one LPC bus; both are checked against a queue model.
module tb_lpc_postcode_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, wren, rden;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout0, dout1;
  logic        hit0, hit1;
  logic [7:0]  pc0;
  logic [15:0] pc1;
  logic [5:0]  cnt0, cnt1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #15 clk = ~clk;

  lpc_postcode_fifo #(.CODE_BYTES(1), .DEPTH(DEPTH)) u_dut_1b (
    .lclk(clk), .lreset_n(rst_n), .lpc_en(en), .lpc_addr(addr), .din(din),
    .io_wren(wren), .io_rden(rden), .dout(dout0), .rd_hit(hit0),
    .postcode(pc0), .count(cnt0)
  );

  lpc_postcode_fifo #(.CODE_BYTES(2), .DEPTH(DEPTH)) u_dut_2b (
    .lclk(clk), .lreset_n(rst_n), .lpc_en(en), .lpc_addr(addr), .din(din),
    .io_wren(wren), .io_rden(rden), .dout(dout1), .rd_hit(hit1),
    .postcode(pc1), .count(cnt1)
  );

  // ---------------- reference model (id 0: 1-byte codes, id 1: 2-byte codes) ----------------
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] m_pc    [2];
  logic        m_ovf   [2];
  int          m_bidx  [2];
  logic [31:0] m_stage [2];

  function automatic int m_size(input int id);
    return (id == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [31:0] m_front(input int id);
    return (id == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic m_pop(input int id);
    if (id == 0) mq0.delete(0); else mq1.delete(0);
  endtask

  task automatic m_flush(input int id);
    if (id == 0) mq0.delete(); else mq1.delete();
    m_bidx[id] = 0;
  endtask

  task automatic m_push(input int id, input logic [31:0] c);
    if (m_size(id) == DEPTH) begin
      m_pop(id);
      m_ovf[id] = 1'b1;
    end
    if (id == 0) mq0.push_back(c); else mq1.push_back(c);
  endtask

  task automatic m_reset();
    for (int id = 0; id < 2; id++) begin
      m_flush(id);
      m_pc[id]    = '0;
      m_ovf[id]   = 1'b0;
      m_stage[id] = '0;
    end
  endtask

  task automatic m_write(input int id, input logic [15:0] a, input logic [7:0] d);
    int cb;
    int k;
    logic [31:0] c;
    cb = id + 1;
    k  = int'(a) - 32'h80;
    if (k >= 0 && k < cb) begin
      if (k < cb - 1) begin
        m_stage[id][8*k +: 8] = d;
      end else begin
        c = m_stage[id];
        c[8*k +: 8] = d;
`ifdef POSTCODE_DEDUP_EN
        if (c != m_pc[id]) m_push(id, c);
`else
        m_push(id, c);
`endif
        m_pc[id] = c;
      end
    end
    if (a == 16'h0A82) begin
      if (d[6]) m_flush(id);
      if (d[7]) m_ovf[id] = 1'b0;
    end
  endtask

  task automatic m_read(input int id, input logic [15:0] a);
    if (a == 16'h0A83 && m_size(id) > 0) begin
      if (m_bidx[id] == id) begin
        m_pop(id);
        m_bidx[id] = 0;
      end else begin
        m_bidx[id] = m_bidx[id] + 1;
      end
    end
  endtask

  function automatic logic [7:0] m_dout(input int id, input logic [15:0] a);
    logic [31:0] f;
    if (a == 16'h0A82) return {m_ovf[id], m_size(id) == 0, 6'(m_size(id))};
    if (a == 16'h0A83) begin
      if (m_size(id) == 0) return 8'hFF;
      f = m_front(id) >> (8 * m_bidx[id]);
      return f[7:0];
    end
    return 8'h00;
  endfunction

  // ---------------- one bus cycle, checked before and after the sampling edge ----------------
  task automatic bus_op(input logic e, input logic w, input logic r, input logic [15:0] a,
                        input logic [7:0] d, output logic [7:0] o0, output logic [7:0] o1);
    logic [7:0] exp0, exp1;
    logic       exph;
    @(negedge clk);
    en = e; wren = w; rden = r; addr = a; din = d;
    exp0 = m_dout(0, a);
    exp1 = m_dout(1, a);
    exph = (a == 16'h0A82) || (a == 16'h0A83);
    #1;
    o0 = dout0;
    o1 = dout1;
    chk_cnt += 4;
    if (dout0 !== exp0) $display("FAIL dout_1b addr=%h got %h exp %h", a, dout0, exp0); else pass_cnt++;
    if (dout1 !== exp1) $display("FAIL dout_2b addr=%h got %h exp %h", a, dout1, exp1); else pass_cnt++;
    if (hit0 !== exph)  $display("FAIL rd_hit_1b addr=%h got %b exp %b", a, hit0, exph); else pass_cnt++;
    if (hit1 !== exph)  $display("FAIL rd_hit_2b addr=%h got %b exp %b", a, hit1, exph); else pass_cnt++;
    @(posedge clk);
    #1;
    en = 1'b0; wren = 1'b0; rden = 1'b0;
    if (e && w) begin m_write(0, a, d); m_write(1, a, d); end
    if (e && r) begin m_read(0, a);     m_read(1, a);     end
    chk_cnt += 4;
    if (pc0 !== m_pc[0][7:0])       $display("FAIL postcode_1b got %h exp %h", pc0, m_pc[0][7:0]); else pass_cnt++;
    if (pc1 !== m_pc[1][15:0])      $display("FAIL postcode_2b got %h exp %h", pc1, m_pc[1][15:0]); else pass_cnt++;
    if (cnt0 !== 6'(m_size(0)))     $display("FAIL count_1b got %0d exp %0d", cnt0, m_size(0)); else pass_cnt++;
    if (cnt1 !== 6'(m_size(1)))     $display("FAIL count_2b got %0d exp %0d", cnt1, m_size(1)); else pass_cnt++;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, output logic [7:0] o0, output logic [7:0] o1);
    bus_op(1'b1, 1'b1, 1'b0, a, d, o0, o1);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] o0, output logic [7:0] o1);
    bus_op(1'b1, 1'b0, 1'b1, a, 8'h00, o0, o1);
  endtask

  task automatic check_all_zero(input string tag);
    chk_cnt += 8;
    if (dout0 !== 8'h00)  $display("FAIL %s dout_1b got %h exp 00", tag, dout0); else pass_cnt++;
    if (dout1 !== 8'h00)  $display("FAIL %s dout_2b got %h exp 00", tag, dout1); else pass_cnt++;
    if (hit0 !== 1'b0)    $display("FAIL %s rd_hit_1b got %b exp 0", tag, hit0); else pass_cnt++;
    if (hit1 !== 1'b0)    $display("FAIL %s rd_hit_2b got %b exp 0", tag, hit1); else pass_cnt++;
    if (pc0 !== 8'h00)    $display("FAIL %s postcode_1b got %h exp 00", tag, pc0); else pass_cnt++;
    if (pc1 !== 16'h0000) $display("FAIL %s postcode_2b got %h exp 0000", tag, pc1); else pass_cnt++;
    if (cnt0 !== 6'd0)    $display("FAIL %s count_1b got %0d exp 0", tag, cnt0); else pass_cnt++;
    if (cnt1 !== 6'd0)    $display("FAIL %s count_2b got %0d exp 0", tag, cnt1); else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; wren = 1'b0; rden = 1'b0; addr = 16'h0000; din = 8'h00;
    m_reset();
    #47;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] o0, o1;
    wr(16'h0080, 8'h11, o0, o1);
    wr(16'h0080, 8'h22, o0, o1);
    wr(16'h0080, 8'h33, o0, o1);
    chk_cnt++;
    if (pc0 !== 8'h33) $display("FAIL sb_postcode got %h exp 33", pc0); else pass_cnt++;
    rd(16'h0A82, o0, o1);
    chk_cnt++;
    if (o0 !== 8'h03) $display("FAIL sb_stat got %h exp 03", o0); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = 8'(8'h11 * (i + 1));
      rd(16'h0A83, o0, o1);
      chk_cnt++;
      if (o0 !== e) $display("FAIL sb_data%0d got %h exp %h", i, o0, e); else pass_cnt++;
    end
    rd(16'h0A82, o0, o1);
    chk_cnt++;
    if (o0 !== 8'h40) $display("FAIL sb_stat_empty got %h exp 40", o0); else pass_cnt++;
    rd(16'h0A83, o0, o1);
    chk_cnt++;
    if (o0 !== 8'hFF) $display("FAIL sb_data_empty got %h exp FF", o0); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] o0, o1;
    wr(16'h0A82, 8'hC0, o0, o1);
    for (int i = 1; i <= 6; i++) wr(16'h0080, 8'(i), o0, o1);
    rd(16'h0A82, o0, o1);
    chk_cnt++;
    if (o0 !== 8'h84) $display("FAIL ovf_stat got %h exp 84", o0); else pass_cnt++;
    for (int i = 3; i <= 6; i++) begin
      rd(16'h0A83, o0, o1);
      chk_cnt++;
      if (o0 !== 8'(i)) $display("FAIL ovf_data got %h exp %h", o0, 8'(i)); else pass_cnt++;
    end
    wr(16'h0A82, 8'h80, o0, o1);
    rd(16'h0A82, o0, o1);
    chk_cnt++;
    if (o0 !== 8'h40) $display("FAIL ovf_clear got %h exp 40", o0); else pass_cnt++;
  endtask

  task automatic test_two_byte();
    logic [7:0] o0, o1;
    wr(16'h0A82, 8'hC0, o0, o1);
    wr(16'h0080, 8'hCD, o0, o1);
    wr(16'h0081, 8'hAB, o0, o1);
    chk_cnt++;
    if (pc1 !== 16'hABCD) $display("FAIL tb_postcode got %h exp ABCD", pc1); else pass_cnt++;
    rd(16'h0A83, o0, o1);
    chk_cnt += 2;
    if (o1 !== 8'hCD) $display("FAIL tb_data_lo got %h exp CD", o1); else pass_cnt++;
    if (cnt1 !== 6'd1) $display("FAIL tb_count_mid got %0d exp 1", cnt1); else pass_cnt++;
    rd(16'h0A83, o0, o1);
    chk_cnt += 2;
    if (o1 !== 8'hAB) $display("FAIL tb_data_hi got %h exp AB", o1); else pass_cnt++;
    if (cnt1 !== 6'd0) $display("FAIL tb_count_end got %0d exp 0", cnt1); else pass_cnt++;
  endtask

  task automatic test_dedup();
    logic [7:0] o0, o1;
    logic [5:0] e;
`ifdef POSTCODE_DEDUP_EN
    e = 6'd1;
`else
    e = 6'd2;
`endif
    wr(16'h0A82, 8'hC0, o0, o1);
    wr(16'h0080, 8'h81, o0, o1);
    wr(16'h0080, 8'h81, o0, o1);
    chk_cnt++;
    if (cnt0 !== e) $display("FAIL dedup_count got %0d exp %0d", cnt0, e); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] o0, o1;
    wr(16'h0A82, 8'hC0, o0, o1);
    for (int i = 0; i < 3; i++) begin
      wr(16'h0080, 8'(8'h20 + i), o0, o1);
      wr(16'h0081, 8'(8'h90 + i), o0, o1);
    end
    rd(16'h0A83, o0, o1);
    wr(16'h0080, 8'h5A, o0, o1);
    @(negedge clk);
    addr = 16'h0000;
    #5 rst_n = 1'b0;
    m_reset();
    #2;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    rd(16'h0A83, o0, o1);
    chk_cnt += 2;
    if (o0 !== 8'hFF) $display("FAIL rm_data_1b got %h exp FF", o0); else pass_cnt++;
    if (o1 !== 8'hFF) $display("FAIL rm_data_2b got %h exp FF", o1); else pass_cnt++;
  endtask

  task automatic test_full_flush();
    logic [7:0] o0, o1;
    wr(16'h0A82, 8'hC0, o0, o1);
    for (int i = 0; i < 5; i++) wr(16'h0080, 8'(8'h10 + i), o0, o1);
    wr(16'h0A82, 8'hC0, o0, o1);
    rd(16'h0A82, o0, o1);
    chk_cnt += 3;
    if (o0 !== 8'h40)  $display("FAIL ff_stat_1b got %h exp 40", o0); else pass_cnt++;
    if (o1 !== 8'h40)  $display("FAIL ff_stat_2b got %h exp 40", o1); else pass_cnt++;
    if (pc0 !== 8'h14) $display("FAIL ff_postcode got %h exp 14", pc0); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0]  o0, o1;
    logic [15:0] a;
    logic [7:0]  d;
    logic        w, e;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 6:    a = 16'h0080;
        1, 7:    a = 16'h0081;
        2:       a = 16'h0082;
        3:       a = 16'h0A82;
        4, 5:    a = 16'h0A83;
        8:       a = 16'($urandom);
        default: a = 16'h0A81;
      endcase
      w = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) != 0);
      d = 8'($urandom);
      if (a == 16'h0A82) d[6] = ($urandom_range(0, 7) == 0);
      bus_op(e, w, !w, a, d, o0, o1);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_two_byte();
    test_dedup();
    test_reset_mid();
    test_full_flush();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
